osd_mam_sram_if: RTL and testbench

//  Memory-side adapter for the MAM: consumes the MAM request/write/read handshakes and

---
 rtl/osd_mam_sram_if_if.sv | 32 +++
 rtl/osd_mam_sram_if.sv | 130 +++++++++++++
 tb/tb_osd_mam_sram_if.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_mam_sram_if_if.sv
// rtl/osd_mam_sram_if_if.sv - MAM-side request/write/read handshake bundle
// Master drives requests and write words; slave returns read words.
interface osd_mam_sram_if_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_burst;
  logic [13:0]             req_beats;
  logic                    write_valid;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;
  logic                    write_ready;
  logic                    read_valid;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_burst, req_beats,
    output write_valid, write_data, write_strb, read_ready,
    input  req_ready, write_ready, read_valid, read_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_burst, req_beats,
    input  write_valid, write_data, write_strb, read_ready,
    output req_ready, write_ready, read_valid, read_data
  );
endinterface

// File: rtl/osd_mam_sram_if.sv
// rtl/osd_mam_sram_if.sv - MAM to single-port SRAM adapter with burst expansion and 2-entry read FIFO
// Optional range checking via OSD_MAM_SRAM_BOUNDS_EN.
module osd_mam_sram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int SRAM_AW    = 16,
  parameter int MEM_WORDS  = 2**SRAM_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  osd_mam_sram_if_if.slave        mam,
  output logic                    sram_ce,
  output logic                    sram_we,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [DATA_WIDTH/8-1:0] sram_be,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    err
);

  localparam int BW    = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BW);
  localparam logic [SRAM_AW:0] MEM_LIMIT = (SRAM_AW+1)'(MEM_WORDS);
`ifdef OSD_MAM_SRAM_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state, state_nxt;
  logic [SRAM_AW-1:0]    waddr;
  logic [13:0]           beats;
  logic [BW-1:0]         be;
  logic                  inflight, inflight_zero;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;
  logic                  err_q;

  logic accept, beat_write, issue, oob, access, push, pop;

  assign mam.req_ready  = (state == IDLE) && !rst;
  assign accept         = mam.req_valid && mam.req_ready;
  assign mam.read_valid = (fifo_count != 2'd0);
  assign mam.read_data  = mam.read_valid ? fifo_mem[rd_ptr] : '0;
  assign pop            = (state == READ) && mam.read_valid && mam.read_ready;
  assign push           = inflight;
  assign oob            = BOUNDS_EN && ({1'b0, waddr} >= MEM_LIMIT);
  assign err            = err_q && BOUNDS_EN;

  // Issue budget counts the slot freed by a same-cycle pop so reads stream at full rate.
  always_comb begin
    state_nxt       = state;
    beat_write      = 1'b0;
    issue           = 1'b0;
    mam.write_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = mam.req_rw ? WRITE : READ;
      end
      WRITE: begin
        mam.write_ready = (beats != 14'd0);
        if (beats == 14'd0) begin
          state_nxt = IDLE;
        end else if (mam.write_valid) begin
          beat_write = 1'b1;
          if (beats == 14'd1) state_nxt = IDLE;
        end
      end
      READ: begin
        issue = (beats != 14'd0) &&
                (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        if ((beats == 14'd0) && !inflight &&
            ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign access     = (beat_write || issue) && !oob;
  assign sram_ce    = access;
  assign sram_we    = beat_write && !oob;
  assign sram_addr  = access ? waddr : '0;
  assign sram_be    = (beat_write && !oob) ? be : ((issue && !oob) ? {BW{1'b1}} : '0);
  assign sram_wdata = (beat_write && !oob) ? mam.write_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      waddr         <= '0;
      beats         <= '0;
      be            <= '0;
      inflight      <= 1'b0;
      inflight_zero <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
      err_q         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        waddr <= mam.req_addr[SHIFT +: SRAM_AW];
        beats <= mam.req_burst ? mam.req_beats : 14'd1;
        be    <= mam.req_burst ? {BW{1'b1}} : mam.write_strb;
      end else if (beat_write || issue) begin
        waddr <= waddr + 1'b1;
        beats <= beats - 14'd1;
      end
      inflight      <= issue;
      inflight_zero <= issue && oob;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      if ((beat_write || issue) && oob) err_q <= 1'b1;
    end
  end

  // Out-of-range reads return zero in place of the (unaccessed) SRAM output.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= inflight_zero ? '0 : sram_rdata;
  end

endmodule

// File: tb/tb_osd_mam_sram_if.sv
// tb/tb_osd_mam_sram_if.sv - directed self-checking bench for osd_mam_sram_if
// Bounds-specific steps run only when OSD_MAM_SRAM_BOUNDS_EN is defined.
module tb_osd_mam_sram_if;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SAW = 8;
`ifdef OSD_MAM_SRAM_BOUNDS_EN
  localparam int MW = 128;
`else
  localparam int MW = 256;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sram_ce, sram_we;
  logic [SAW-1:0] sram_addr;
  logic [1:0]     sram_be;
  logic [DW-1:0]  sram_wdata;
  logic [DW-1:0]  sram_rdata;
  logic           err;
  logic [DW-1:0]  mem [256];

  int n_checks = 0;
  int n_err    = 0;

  osd_mam_sram_if_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mam ();

  osd_mam_sram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_AW(SAW), .MEM_WORDS(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mam        (mam),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_be    (sram_be),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-enabled writes, one-cycle registered read.
  always @(posedge clk) begin
    if (sram_ce && sram_we) begin
      if (sram_be[0]) mem[sram_addr][7:0]  <= sram_wdata[7:0];
      if (sram_be[1]) mem[sram_addr][15:8] <= sram_wdata[15:8];
    end
    if (sram_ce && !sram_we) sram_rdata <= mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic request(input logic rw, input logic [31:0] addr, input logic burst,
                         input logic [13:0] nbeats, input logic [1:0] strb);
    mam.req_valid  = 1'b1;
    mam.req_rw     = rw;
    mam.req_addr   = addr;
    mam.req_burst  = burst;
    mam.req_beats  = nbeats;
    mam.write_strb = strb;
    tick();
    mam.req_valid  = 1'b0;
  endtask

  logic [15:0] exp_words [5];
  int          got;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    sram_rdata      = '0;
    mem[4]          = 16'h5555;
    mem[8'h40]      = 16'hA1A1;
    mem[8'h41]      = 16'hB2B2;
    mem[8'h42]      = 16'hC3C3;
    mam.req_valid   = 1'b0;
    mam.req_rw      = 1'b0;
    mam.req_addr    = '0;
    mam.req_burst   = 1'b0;
    mam.req_beats   = '0;
    mam.write_valid = 1'b0;
    mam.write_data  = '0;
    mam.write_strb  = '0;
    mam.read_ready  = 1'b0;

    // Outputs held low during reset, idle after release.
    #2;
    check("rst_req_ready", mam.req_ready, 0);
    check("rst_ce", sram_ce, 0);
    check("rst_err", err, 0);
    tick(); tick();
    rst = 1'b0;
    mid();
    check("idle_req_ready", mam.req_ready, 1);
    check("idle_ce", sram_ce, 0);
    check("idle_read_valid", mam.read_valid, 0);

    // Write data outside WRITE is refused.
    mam.write_valid = 1'b1;
    mam.write_data  = 16'h1234;
    #1;
    check("idle_write_ready", mam.write_ready, 0);
    check("idle_write_ce", sram_ce, 0);
    mam.write_valid = 1'b0;
    tick();

    // Single write with strobe 01; req_beats ignored.
    request(1'b1, 32'h20, 1'b0, 14'd7, 2'b01);
    mam.write_valid = 1'b1;
    mam.write_data  = 16'hBEEF;
    mid();
    check("sw_ce", sram_ce, 1);
    check("sw_we", sram_we, 1);
    check("sw_addr", sram_addr, 8'h10);
    check("sw_be", sram_be, 2'b01);
    check("sw_wdata", sram_wdata, 16'hBEEF);
    check("sw_write_ready", mam.write_ready, 1);
    tick();
    mam.write_valid = 1'b0;
    mid();
    check("sw_back_idle", mam.req_ready, 1);
    check("sw_mem", mem[8'h10], 16'h00EF);
    tick();

    // Burst write of 4 words at address 0.
    request(1'b1, 32'h0, 1'b1, 14'd4, 2'b00);
    mam.write_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mam.write_data = 16'(i + 1);
      mid();
      check("bw_ce", sram_ce, 1);
      check("bw_addr", sram_addr, 32'(i));
      check("bw_be", sram_be, 2'b11);
      check("bw_wdata", sram_wdata, 32'(i + 1));
      tick();
    end
    mid();
    check("bw_req_ready_after", mam.req_ready, 1);
    check("bw_ce_after", sram_ce, 0);
    mam.write_valid = 1'b0;
    tick();

    // Burst read of 3 words at word 0x40 with read_ready held high.
    mam.read_ready = 1'b1;
    request(1'b0, 32'h80, 1'b1, 14'd3, 2'b00);
    mid();
    check("br_c1_ce", sram_ce, 1);
    check("br_c1_we", sram_we, 0);
    check("br_c1_addr", sram_addr, 8'h40);
    check("br_c1_be", sram_be, 2'b11);
    check("br_c1_valid", mam.read_valid, 0);
    tick(); mid();
    check("br_c2_addr", sram_addr, 8'h41);
    check("br_c2_valid", mam.read_valid, 0);
    tick(); mid();
    check("br_c3_valid", mam.read_valid, 1);
    check("br_c3_data", mam.read_data, 16'hA1A1);
    check("br_c3_addr", sram_addr, 8'h42);
    tick(); mid();
    check("br_c4_data", mam.read_data, 16'hB2B2);
    check("br_c4_ce", sram_ce, 0);
    tick(); mid();
    check("br_c5_data", mam.read_data, 16'hC3C3);
    check("br_c5_valid", mam.read_valid, 1);
    tick(); mid();
    check("br_done_valid", mam.read_valid, 0);
    check("br_done_idle", mam.req_ready, 1);
    tick();

    // Read backpressure: 5 beats, read_ready low for 4 cycles.
    mam.read_ready = 1'b0;
    request(1'b0, 32'h0, 1'b1, 14'd5, 2'b00);
    mid();
    check("bp_c1_ce", sram_ce, 1);
    tick(); mid();
    check("bp_c2_ce", sram_ce, 1);
    tick(); mid();
    check("bp_c3_ce", sram_ce, 0);
    tick(); mid();
    check("bp_c4_ce", sram_ce, 0);
    check("bp_c4_valid", mam.read_valid, 1);
    tick();
    mam.read_ready = 1'b1;
    exp_words[0] = 16'h0001;
    exp_words[1] = 16'h0002;
    exp_words[2] = 16'h0003;
    exp_words[3] = 16'h0004;
    exp_words[4] = 16'h5555;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      mid();
      if (mam.read_valid && got < 5) begin
        check("bp_word", mam.read_data, exp_words[got]);
        got++;
      end
      tick();
    end
    check("bp_word_count", got, 5);
    mid();
    check("bp_idle", mam.req_ready, 1);
    mam.read_ready = 1'b0;
    tick();

    // Zero-beat burst returns to IDLE without SRAM access.
    request(1'b0, 32'h0, 1'b1, 14'd0, 2'b00);
    mid();
    check("zb_ce", sram_ce, 0);
    check("zb_busy", mam.req_ready, 0);
    tick(); mid();
    check("zb_idle", mam.req_ready, 1);
    tick();

`ifndef OSD_MAM_SRAM_BOUNDS_EN
    // Word address wraps 0xFF -> 0x00.
    request(1'b1, 32'h1FE, 1'b1, 14'd2, 2'b00);
    mam.write_valid = 1'b1;
    mam.write_data  = 16'h7777;
    mid();
    check("wrap_addr0", sram_addr, 8'hFF);
    check("wrap_ce0", sram_ce, 1);
    tick(); mid();
    check("wrap_addr1", sram_addr, 8'h00);
    check("wrap_ce1", sram_ce, 1);
    check("wrap_err", err, 0);
    tick();
    mam.write_valid = 1'b0;
`else
    // Out-of-range read: no SRAM access, zero data, sticky err.
    mam.read_ready = 1'b1;
    request(1'b0, 32'h100, 1'b0, 14'd0, 2'b00);
    mid();
    check("oob_c1_ce", sram_ce, 0);
    tick(); mid();
    check("oob_c2_ce", sram_ce, 0);
    check("oob_err", err, 1);
    tick(); mid();
    check("oob_valid", mam.read_valid, 1);
    check("oob_data", mam.read_data, 0);
    tick(); tick();
    mid();
    check("oob_err_sticky", err, 1);
    mam.read_ready = 1'b0;
    tick();
`endif

    // Asynchronous reset mid-burst forces outputs low immediately.
    request(1'b0, 32'h0, 1'b1, 14'd4, 2'b00);
    mid();
    check("ar_ce_before", sram_ce, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_ce", sram_ce, 0);
    check("ar_req_ready", mam.req_ready, 0);
    check("ar_err", err, 0);
    tick(); tick();
    rst = 1'b0;
    mid();
    check("ar_valid_flushed", mam.read_valid, 0);
    check("ar_ce_after", sram_ce, 0);
    check("ar_idle", mam.req_ready, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
